// File: rtl/alu_seq.sv
// Registered ALU with architectural {Z,C,N,V} status and a valid/ready handshake.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiply on opcode 1010.
module alu_seq #(
   parameter int unsigned WIDTH           = 32,
   parameter int unsigned MUL_CYCLES_LOG2 = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] first,
   input  logic [WIDTH-1:0] second,
   input  logic [3:0]       exe_cmd,
   input  logic             set_flags,
   output logic             out_valid,
   output logic [WIDTH-1:0] alu_result,
   output logic [3:0]       status,
   output logic             cmd_err
);

   if ((WIDTH < 8) || ((64'd1 << MUL_CYCLES_LOG2) < 64'(WIDTH))) begin : g_bad_cfg
      $error("alu_seq: WIDTH must be >= 8 and 2**MUL_CYCLES_LOG2 >= WIDTH");
   end

   typedef enum logic [3:0] {
      OP_MOV = 4'b0001,
      OP_ADD = 4'b0010,
      OP_ADC = 4'b0011,
      OP_SUB = 4'b0100,
      OP_SBC = 4'b0101,
      OP_AND = 4'b0110,
      OP_ORR = 4'b0111,
      OP_EOR = 4'b1000,
      OP_MVN = 4'b1001,
      OP_MUL = 4'b1010
   } op_e;

   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       status_q, status_d;
   logic             out_valid_q, out_valid_d;
   logic             cmd_err_q, cmd_err_d;

   logic [WIDTH:0]   ext_a, ext_b, wide;
   logic [WIDTH-1:0] alu_r;
   logic [3:0]       alu_flags;
   logic             alu_v, alu_illegal, mul_start, carry_in, accept;

   assign carry_in = status_q[2];
   assign accept   = in_valid & in_ready;

   // Single-cycle datapath; bit WIDTH of the widened result is the carry/borrow.
   always_comb begin
      ext_a       = {1'b0, first};
      ext_b       = {1'b0, second};
      wide        = '0;
      alu_v       = 1'b0;
      alu_illegal = 1'b0;
      mul_start   = 1'b0;
      case (exe_cmd)
         OP_MOV: wide = ext_b;
         OP_MVN: wide = {1'b0, ~second};
         OP_ADD, OP_ADC: begin
            wide  = ext_a + ext_b + {{WIDTH{1'b0}}, (exe_cmd == OP_ADC) & carry_in};
            alu_v = (first[WIDTH-1] == second[WIDTH-1]) && (wide[WIDTH-1] != first[WIDTH-1]);
         end
         OP_SUB, OP_SBC: begin
            wide  = ext_a - ext_b - {{WIDTH{1'b0}}, (exe_cmd == OP_SBC) & ~carry_in};
            alu_v = (first[WIDTH-1] != second[WIDTH-1]) && (wide[WIDTH-1] != first[WIDTH-1]);
         end
         OP_AND: wide = {1'b0, first & second};
         OP_ORR: wide = {1'b0, first | second};
         OP_EOR: wide = {1'b0, first ^ second};
`ifdef ALU_SEQ_MUL_EN
         OP_MUL: mul_start = 1'b1;
`endif
         default: alu_illegal = 1'b1;
      endcase
      alu_r     = wide[WIDTH-1:0];
      alu_flags = {alu_r == '0, wide[WIDTH], alu_r[WIDTH-1], alu_v};
   end

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_e;

   state_e                     state_q, state_d;
   logic [MUL_CYCLES_LOG2-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]           mcand_q, mcand_d;
   logic [WIDTH-1:0]           mplier_q, mplier_d;
   logic [WIDTH-1:0]           acc_q, acc_d;
   logic                       mul_sf_q, mul_sf_d;
   logic [WIDTH-1:0]           acc_step;

   assign in_ready = (state_q == S_IDLE);
`else
   assign in_ready = 1'b1;
`endif

   always_comb begin
      result_d    = result_q;
      status_d    = status_q;
      out_valid_d = 1'b0;
      cmd_err_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      mul_sf_d    = mul_sf_q;
      acc_step    = '0;
`endif
      if (accept && !mul_start) begin
         out_valid_d = 1'b1;
         if (alu_illegal) begin
            result_d  = '0;
            cmd_err_d = 1'b1;
         end else begin
            result_d = alu_r;
            if (set_flags) status_d = alu_flags;
         end
      end
`ifdef ALU_SEQ_MUL_EN
      if (accept && mul_start) begin
         state_d  = S_MUL;
         cnt_d    = '0;
         mcand_d  = first;
         mplier_d = second;
         acc_d    = '0;
         mul_sf_d = set_flags;
      end
      // One conditional add per cycle; the final step writes the result directly.
      if (state_q == S_MUL) begin
         acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == MUL_CYCLES_LOG2'(WIDTH - 1)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            result_d    = acc_step;
            if (mul_sf_q) status_d = {acc_step == '0, 1'b0, acc_step[WIDTH-1], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         status_q    <= '0;
         out_valid_q <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         result_q    <= result_d;
         status_q    <= status_d;
         out_valid_q <= out_valid_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

`ifdef ALU_SEQ_MUL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         mul_sf_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         mul_sf_q <= mul_sf_d;
      end
   end
`endif

   assign out_valid  = out_valid_q;
   assign alu_result = result_q;
   assign status     = status_q;
   assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq against a behavioural model (WIDTH=32), plus literal spot checks.
module tb_alu_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  first = '0;
   logic [W-1:0]  second = '0;
   logic [3:0]    exe_cmd = '0;
   logic          set_flags = 1'b0;
   logic          out_valid;
   logic [W-1:0]  alu_result;
   logic [3:0]    status;
   logic          cmd_err;

   int checks = 0;
   int errors = 0;
   logic cmp_en = 1'b0;

   alu_seq #(.WIDTH(W), .MUL_CYCLES_LOG2(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .first(first), .second(second), .exe_cmd(exe_cmd), .set_flags(set_flags),
      .out_valid(out_valid), .alu_result(alu_result), .status(status), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference semantics from plain integer arithmetic.
   function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, output logic [W-1:0] res, output logic [3:0] fl,
                                   output logic illegal, output logic is_mul);
      longint ua, ub, sa, sb, x, full, sr, maxs, mins;
      logic c, v;
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      maxs = 2147483647;
      mins = -maxs - 1;
      c = 1'b0; v = 1'b0; illegal = 1'b0; is_mul = 1'b0; res = '0;
      case (op)
         4'b0001: res = b;
         4'b1001: res = ~b;
         4'b0010, 4'b0011: begin
            x = (op == 4'b0011 && cin) ? 1 : 0;
            full = ua + ub + x;
            res = full[W-1:0];
            c = (full > 64'hFFFF_FFFF);
            sr = sa + sb + x;
            v = (sr > maxs) || (sr < mins);
         end
         4'b0100, 4'b0101: begin
            x = (op == 4'b0101 && !cin) ? 1 : 0;
            full = ua - ub - x;
            res = full[W-1:0];
            c = (full < 0);
            sr = sa - sb - x;
            v = (sr > maxs) || (sr < mins);
         end
         4'b0110: res = a & b;
         4'b0111: res = a | b;
         4'b1000: res = a ^ b;
`ifdef ALU_SEQ_MUL_EN
         4'b1010: begin
            is_mul = 1'b1;
            full = ua * ub;
            res = full[W-1:0];
         end
`endif
         default: illegal = 1'b1;
      endcase
      fl = {res == '0, c, res[W-1], v};
   endfunction

   logic [W-1:0] m_result = '0;
   logic [3:0]   m_status = '0;
   logic         m_valid = 1'b0;
   logic         m_err = 1'b0;
   int           m_busy = 0;
   logic [W-1:0] m_pend = '0;
   logic         m_pend_sf = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      logic [W-1:0] r;
      logic [3:0]   f;
      logic         ill, ism;
      if (!rst_n) begin
         m_result = '0; m_status = '0; m_valid = 1'b0; m_err = 1'b0; m_busy = 0;
      end else begin
         m_valid = 1'b0;
         m_err = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_valid = 1'b1;
               m_result = m_pend;
               if (m_pend_sf) m_status = {m_pend == '0, 1'b0, m_pend[W-1], 1'b0};
            end
         end else if (in_valid) begin
            ref_alu(exe_cmd, first, second, m_status[2], r, f, ill, ism);
            if (ill) begin
               m_valid = 1'b1; m_err = 1'b1; m_result = '0;
            end else if (ism) begin
               m_busy = W; m_pend = r; m_pend_sf = set_flags;
            end else begin
               m_valid = 1'b1; m_result = r;
               if (set_flags) m_status = f;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         chk("out_valid", out_valid, m_valid);
         chk("in_ready", in_ready, m_busy == 0);
         chk("status", status, m_status);
         chk("alu_result", alu_result, m_result);
         if (m_valid) chk("cmd_err", cmd_err, m_err);
      end
   end

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic sf);
      in_valid = 1'b1; exe_cmd = op; first = a; second = b; set_flags = sf;
      @(posedge clk); #2;
      in_valid = 1'b0; first = $urandom; second = $urandom; exe_cmd = 4'($urandom);
   endtask

   task automatic async_reset_check(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_result"}, alu_result, 0);
      chk({tag, "_rst_status"}, status, 0);
      chk({tag, "_rst_valid"}, out_valid, 0);
      chk({tag, "_rst_err"}, cmd_err, 0);
      chk({tag, "_rst_ready"}, in_ready, 1);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("reset_result", alu_result, 0);
      chk("reset_status", status, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_ready", in_ready, 1);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      chk("add_valid", out_valid, 1);
      chk("add_result", alu_result, 32'h8000_0000);
      chk("add_status", status, 4'b0011);
      issue(4'b0011, 32'h1, 32'h1, 1'b0);
      chk("adc_result", alu_result, 32'h2);
      chk("adc_status", status, 4'b0011);

      issue(4'b0100, 32'd5, 32'd5, 1'b1);
      chk("sub_result", alu_result, 0);
      chk("sub_status", status, 4'b1000);
      issue(4'b0101, 32'd10, 32'd3, 1'b0);
      chk("sbc_result", alu_result, 32'd6);

      issue(4'b1000, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0);
      chk("eor_valid", out_valid, 1);
      chk("eor_result", alu_result, 32'hFF00_12CB);
      issue(4'b0110, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0);
      chk("and_valid", out_valid, 1);
      chk("and_result", alu_result, 32'h00F0_0034);
      issue(4'b0111, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0);
      chk("orr_valid", out_valid, 1);
      chk("orr_result", alu_result, 32'hFFF0_12FF);
      chk("logic_status", status, 4'b1000);

      issue(4'b1111, 32'h1234, 32'h5678, 1'b1);
      chk("ill_valid", out_valid, 1);
      chk("ill_err", cmd_err, 1);
      chk("ill_result", alu_result, 0);
      chk("ill_status", status, 4'b1000);

      issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1);
      chk("carry_status", status, 4'b1100);
      @(posedge clk); #2;
      issue(4'b0011, 32'h0, 32'h0, 1'b0);
      chk("adc_carry_in", alu_result, 32'h1);

`ifdef ALU_SEQ_MUL_EN
      issue(4'b1010, 32'h0001_0003, 32'h0000_0005, 1'b1);
      for (int i = 1; i <= 32; i++) begin
         chk("mul_busy_ready", in_ready, 0);
         chk("mul_busy_valid", out_valid, 0);
         @(posedge clk); #2;
      end
      chk("mul_valid", out_valid, 1);
      chk("mul_result", alu_result, 32'h0005_000F);
      chk("mul_ready", in_ready, 1);
      chk("mul_status", status, 4'b0000);

      issue(4'b1010, 32'h0001_0003, 32'h0000_0005, 1'b0);
      repeat (9) @(posedge clk);
      #2;
      async_reset_check("mul_abort");
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         chk("abort_no_valid", out_valid, 0);
      end
`else
      issue(4'b1010, 32'h0001_0003, 32'h0000_0005, 1'b1);
      chk("mul_ill_valid", out_valid, 1);
      chk("mul_ill_err", cmd_err, 1);
      chk("mul_ill_result", alu_result, 0);
      chk("mul_ill_ready", in_ready, 1);
`endif

      issue(4'b0100, 32'h3, 32'h5, 1'b1);
      async_reset_check("midstream");

      for (int n = 0; n < 3000; n++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         exe_cmd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 9));
         first = pick_operand();
         second = pick_operand();
         set_flags = $urandom_range(0, 1) != 0;
         @(posedge clk); #2;
      end
      in_valid = 1'b0;
      repeat (40) @(posedge clk);
      #2;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
